// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the register file: pipeline writeback (A) has fixed priority over the MDU (B),
// with a starvation guard for B and a busy scoreboard of MDU destinations for decode hazard detection.
module regfile_write_arbiter #(
    parameter int unsigned DW           = 32,
    parameter int unsigned AW           = 5,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    input  logic [AW-1:0] a_reg,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_reg,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_reg,
    output logic          issue_ready,
    input  logic [AW-1:0] rs_check,
    input  logic [AW-1:0] rt_check,
    output logic          hazard_stall,
    output logic [AW-1:0] Write_register,
    output logic [DW-1:0] Write_data,
    output logic          RegWrite,
    output logic          sb_error
);

    localparam int unsigned NREG = 1 << AW;
    localparam int unsigned CW   = 4;
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    logic [CW-1:0]   starve_cnt;
    logic [CW-1:0]   starve_cnt_nxt;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            sb_error_nxt;
    logic            b_xfer_nz;

    // Grant and write-port mux; B wins only once it has waited STARVE_LIMIT cycles.
    always_comb begin
        a_ready        = a_valid && !(b_valid && (starve_cnt == STARVE_MAX));
        b_ready        = b_valid && !a_ready;
        Write_register = '0;
        Write_data     = '0;
        if (a_ready) begin
            Write_register = a_reg;
            Write_data     = a_data;
        end else if (b_ready) begin
            Write_register = b_reg;
            Write_data     = b_data;
        end
        RegWrite = (a_ready || b_ready) && (Write_register != '0);
    end

    always_comb begin
        issue_ready  = !busy[issue_reg] || (issue_reg == '0);
        hazard_stall = busy[rs_check] || busy[rt_check];
    end

    // Next-state for starvation counter, scoreboard and sticky error; issue set is applied after B clear.
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        busy_nxt       = busy;
        sb_error_nxt   = sb_error;
        b_xfer_nz      = b_ready && (b_reg != '0);

        if (!b_valid || b_ready) begin
            starve_cnt_nxt = '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt_nxt = starve_cnt + CW'(1);
        end

        if (b_xfer_nz) begin
            busy_nxt[b_reg] = 1'b0;
            if (!busy[b_reg]) begin
                sb_error_nxt = 1'b1;
            end
        end
        if (issue_valid && issue_ready && (issue_reg != '0)) begin
            busy_nxt[issue_reg] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            busy       <= '0;
            sb_error   <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
            busy       <= busy_nxt;
            sb_error   <= sb_error_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: grant priority, starvation guard, scoreboard and sticky error.
module tb_regfile_write_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk;
    logic          rst_n;
    logic          a_valid, b_valid, issue_valid;
    logic [AW-1:0] a_reg, b_reg, issue_reg, rs_check, rt_check;
    logic [DW-1:0] a_data, b_data;
    logic          a_ready, b_ready, issue_ready, hazard_stall;
    logic [AW-1:0] Write_register;
    logic [DW-1:0] Write_data;
    logic          RegWrite, sb_error;

    logic [DW-1:0] rf [32];
    int            n_checks;
    int            n_fail;

    regfile_write_arbiter #(.DW(DW), .AW(AW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_ready(issue_ready),
        .rs_check(rs_check), .rt_check(rt_check), .hazard_stall(hazard_stall),
        .Write_register(Write_register), .Write_data(Write_data),
        .RegWrite(RegWrite), .sb_error(sb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple register-file model fed by the arbiter's write port.
    always @(posedge clk) begin
        if (RegWrite) rf[Write_register] <= Write_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        a_valid = 1'b0; a_reg = '0; a_data = '0;
        b_valid = 1'b0; b_reg = '0; b_data = '0;
        issue_valid = 1'b0; issue_reg = '0;
        rs_check = '0; rt_check = '0;
    endtask

    // Advance to the next negedge and clear all requests.
    task automatic next_cycle();
        @(negedge clk);
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) rf[i] = '0;

        // Reset with a request pending
        rst_n = 1'b0;
        idle();
        a_valid = 1'b1;
        rs_check = 5'd4; rt_check = 5'd5;
        #1;
        check("rst_regwrite", 32'(RegWrite), 32'd0);
        check("rst_sb_error", 32'(sb_error), 32'd0);
        check("rst_hazard", 32'(hazard_stall), 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd0);

        // First write after reset release
        next_cycle();
        rst_n = 1'b1;
        a_valid = 1'b1; a_reg = 5'd1; a_data = 32'hfffaff;
        #1;
        check("a_only_ready", 32'(a_ready), 32'd1);
        check("a_only_regwrite", 32'(RegWrite), 32'd1);
        check("a_only_wreg", 32'(Write_register), 32'd1);
        check("a_only_wdata", Write_data, 32'hfffaff);

        // Priority: A over B, B granted once A drops
        next_cycle();
        check("rf1_written", rf[1], 32'hfffaff);
        a_valid = 1'b1; a_reg = 5'd2; a_data = 32'habcdef;
        b_valid = 1'b1; b_reg = 5'd3; b_data = 32'hfafafaf;
        #1;
        check("prio_a_ready", 32'(a_ready), 32'd1);
        check("prio_b_ready", 32'(b_ready), 32'd0);
        check("prio_wreg", 32'(Write_register), 32'd2);
        check("prio_wdata", Write_data, 32'habcdef);
        next_cycle();
        b_valid = 1'b1; b_reg = 5'd3; b_data = 32'hfafafaf;
        #1;
        check("b_only_ready", 32'(b_ready), 32'd1);
        check("b_only_wreg", 32'(Write_register), 32'd3);
        check("b_only_wdata", Write_data, 32'hfafafaf);
        check("b_only_regwrite", 32'(RegWrite), 32'd1);
        next_cycle();
        #1;
        check("b_unbusy_sets_err", 32'(sb_error), 32'd1);
        check("idle_wreg_zero", 32'(Write_register), 32'd0);
        check("idle_regwrite", 32'(RegWrite), 32'd0);

        // Starvation: B waits exactly 4 cycles, then gets one grant
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            a_valid = 1'b1; a_reg = 5'd2; a_data = 32'h11;
            b_valid = 1'b1; b_reg = 5'd3; b_data = 32'h22;
            #1;
            check($sformatf("starve_b_wait%0d", i), 32'(b_ready), 32'd0);
            check($sformatf("starve_a_go%0d", i), 32'(a_ready), 32'd1);
        end
        next_cycle();
        a_valid = 1'b1; a_reg = 5'd2; a_data = 32'h11;
        b_valid = 1'b1; b_reg = 5'd3; b_data = 32'h22;
        #1;
        check("starve_a_stalled", 32'(a_ready), 32'd0);
        check("starve_b_granted", 32'(b_ready), 32'd1);
        check("starve_wreg", 32'(Write_register), 32'd3);
        next_cycle();
        a_valid = 1'b1; a_reg = 5'd2; a_data = 32'h11;
        b_valid = 1'b1; b_reg = 5'd3; b_data = 32'h22;
        #1;
        check("starve_cnt_cleared_a", 32'(a_ready), 32'd1);
        check("starve_cnt_cleared_b", 32'(b_ready), 32'd0);

        // Scoreboard: issue 4, hazard, duplicate issue blocked, B write clears
        next_cycle();
        issue_valid = 1'b1; issue_reg = 5'd4; rs_check = 5'd4;
        #1;
        check("issue4_ready", 32'(issue_ready), 32'd1);
        check("issue4_no_hazard_yet", 32'(hazard_stall), 32'd0);
        next_cycle();
        issue_valid = 1'b1; issue_reg = 5'd4; rs_check = 5'd4;
        #1;
        check("busy4_hazard_rs", 32'(hazard_stall), 32'd1);
        check("reissue4_blocked", 32'(issue_ready), 32'd0);
        next_cycle();
        rt_check = 5'd4;
        b_valid = 1'b1; b_reg = 5'd4; b_data = 32'haddfa;
        #1;
        check("b4_ready", 32'(b_ready), 32'd1);
        check("b4_wdata", Write_data, 32'haddfa);
        check("b4_hazard_same_cycle", 32'(hazard_stall), 32'd1);
        next_cycle();
        rs_check = 5'd4; rt_check = 5'd4;
        #1;
        check("b4_hazard_released", 32'(hazard_stall), 32'd0);
        check("rf4_written", rf[4], 32'haddfa);

        // Set/clear collision on reg 3: set wins
        next_cycle();
        issue_valid = 1'b1; issue_reg = 5'd3;
        b_valid = 1'b1; b_reg = 5'd3; b_data = 32'h33;
        #1;
        check("coll_issue_ready", 32'(issue_ready), 32'd1);
        check("coll_b_ready", 32'(b_ready), 32'd1);
        next_cycle();
        rs_check = 5'd3;
        #1;
        check("coll_busy3_set", 32'(hazard_stall), 32'd1);

        // Register 0: handshakes complete without writes or busy changes
        next_cycle();
        issue_valid = 1'b1; issue_reg = 5'd0;
        b_valid = 1'b1; b_reg = 5'd0; b_data = 32'hdead;
        #1;
        check("r0_issue_ready", 32'(issue_ready), 32'd1);
        check("r0_b_ready", 32'(b_ready), 32'd1);
        check("r0_b_regwrite", 32'(RegWrite), 32'd0);
        next_cycle();
        a_valid = 1'b1; a_reg = 5'd0; a_data = 32'hbeef;
        #1;
        check("r0_hazard", 32'(hazard_stall), 32'd0);
        check("r0_a_ready", 32'(a_ready), 32'd1);
        check("r0_a_regwrite", 32'(RegWrite), 32'd0);

        // Mid-operation reset drops busy bits and the error flag
        next_cycle();
        rs_check = 5'd3;
        rst_n = 1'b0;
        #1;
        check("midrst_sb_error", 32'(sb_error), 32'd0);
        check("midrst_busy_lost", 32'(hazard_stall), 32'd0);
        #1;
        rst_n = 1'b1;

        // Sticky error from an unexpected B write to reg 5
        next_cycle();
        b_valid = 1'b1; b_reg = 5'd5; b_data = 32'h55;
        #1;
        check("err_before", 32'(sb_error), 32'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            check($sformatf("err_sticky%0d", i), 32'(sb_error), 32'd1);
        end
        next_cycle();
        rst_n = 1'b0;
        #1;
        check("err_cleared_by_reset", 32'(sb_error), 32'd0);
        rst_n = 1'b1;

        next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
